// File: rtl/ysyx_24070003_lsu.sv
// Load/store unit: accepts one instruction from execute, performs at most one
// word-aligned memory transaction, and hands the result to writeback.
module ysyx_24070003_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_wen,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wmask,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        is_load_q;

  logic        is_load_c;
  logic        is_store_c;
  logic        misaligned_c;
  logic [3:0]  wmask_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted_c;
  logic        b_sign_c;
  logic        h_sign_c;
  logic [31:0] load_data_c;

  // Decode of the incoming instruction; both rd and wr set counts as pass-through
  always_comb begin
    is_load_c    = in_mem_rd & ~in_mem_wr;
    is_store_c   = in_mem_wr & ~in_mem_rd;
    misaligned_c = (is_load_c | is_store_c) &
                   (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                    (in_funct3[1] & (in_addr[1:0] != 2'b00)));
    wdata_c      = in_wdata << {in_addr[1:0], 3'b000};
    case (in_funct3[1:0])
      2'b00:   wmask_c = 4'b0001 << in_addr[1:0];
      2'b01:   wmask_c = 4'b0011 << in_addr[1:0];
      default: wmask_c = 4'b1111;
    endcase
  end

  // Lane extraction and sign/zero extension of the load response
  always_comb begin
    shifted_c = resp_rdata >> {lane_q, 3'b000};
    b_sign_c  = ~funct3_q[2] & shifted_c[7];
    h_sign_c  = ~funct3_q[2] & shifted_c[15];
    case (funct3_q[1:0])
      2'b00:   load_data_c = {{24{b_sign_c}}, shifted_c[7:0]};
      2'b01:   load_data_c = {{16{h_sign_c}}, shifted_c[15:0]};
      default: load_data_c = resp_rdata;
    endcase
  end

  // Transaction FSM with registered handshakes, request and result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      req_valid <= 1'b0;
      req_addr  <= 32'h0;
      req_wen   <= 1'b0;
      req_wdata <= 32'h0;
      req_wmask <= 4'h0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_rd    <= 5'h0;
      out_err   <= 1'b0;
      lane_q    <= 2'b00;
      funct3_q  <= 3'b000;
      rd_q      <= 5'h0;
      is_load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            lane_q    <= in_addr[1:0];
            funct3_q  <= in_funct3;
            rd_q      <= in_rd;
            is_load_q <= is_load_c;
            if ((is_load_c | is_store_c) & ~misaligned_c) begin
              state     <= REQ;
              req_valid <= 1'b1;
              req_addr  <= {in_addr[31:2], 2'b00};
              req_wen   <= is_store_c;
              req_wdata <= is_store_c ? wdata_c : 32'h0;
              req_wmask <= is_store_c ? wmask_c : 4'h0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_addr;
              out_rd    <= is_store_c ? 5'h0 : in_rd;
              out_err   <= misaligned_c;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= resp_err;
            out_data  <= (is_load_q & ~resp_err) ? load_data_c : 32'h0;
            out_rd    <= is_load_q ? rd_q : 5'h0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24070003_lsu.sv
// Bench for the LSU: directed vector table, random transactions against a
// word-array memory model, and reset/response-timing corner sequences.
module tb_ysyx_24070003_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic        in_mem_rd, in_mem_wr;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          req_stall;
    int          out_stall;
    logic        exp_req;
    logic [31:0] exp_raddr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  ysyx_24070003_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3), .in_rd(in_rd),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rd_en, input logic wr_en, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] rdata, input logic err,
                              input int rs, input int os,
                              input logic e_req, input logic [31:0] e_raddr, input logic e_wen,
                              input logic [31:0] e_wdata, input logic [3:0] e_wmask,
                              input logic [31:0] e_data, input logic [4:0] e_rd, input logic e_err);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd_en = rd_en; v.wr_en = wr_en; v.f3 = f3; v.rd = rd;
    v.rdata = rdata; v.err = err; v.req_stall = rs; v.out_stall = os;
    v.exp_req = e_req; v.exp_raddr = e_raddr; v.exp_wen = e_wen; v.exp_wdata = e_wdata;
    v.exp_wmask = e_wmask; v.exp_data = e_data; v.exp_rd = e_rd; v.exp_err = e_err;
    return v;
  endfunction

  // Reference: access size in bytes, byte offset, and plain arithmetic on lanes
  function automatic vec_t ref_model(input vec_t v);
    vec_t r = v;
    bit ld = v.rd_en && !v.wr_en;
    bit st = v.wr_en && !v.rd_en;
    int size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    int off = int'(v.addr % 4);
    bit mis = (ld || st) && ((off % size) != 0);
    longint val;
    r.exp_req = 0; r.exp_raddr = 0; r.exp_wen = 0; r.exp_wdata = 0; r.exp_wmask = 0;
    if (!(ld || st) || mis) begin
      r.exp_data = v.addr;
      r.exp_err  = mis;
      r.exp_rd   = st ? 5'd0 : v.rd;
    end else begin
      r.exp_req   = 1;
      r.exp_raddr = v.addr - 32'(off);
      r.exp_err   = v.err;
      if (st) begin
        r.exp_wen   = 1;
        r.exp_wmask = 4'(((1 << size) - 1) << off);
        r.exp_wdata = 32'(longint'(v.wdata) << (8 * off));
        r.exp_data  = 0;
        r.exp_rd    = 0;
      end else begin
        val = (longint'(v.rdata) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (!v.f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
          val = val - (longint'(1) << (8 * size));
        r.exp_data = v.err ? 32'd0 : 32'(val);
        r.exp_rd   = v.rd;
      end
    end
    return r;
  endfunction

  // One full instruction: accept, optional memory phase, writeback handshake
  task automatic do_txn(input vec_t v, input bit dirty);
    int lat;
    int k;
    int exp_lat;
    @(negedge clock);
    in_valid = 1; in_addr = v.addr; in_wdata = v.wdata; in_mem_rd = v.rd_en;
    in_mem_wr = v.wr_en; in_funct3 = v.f3; in_rd = v.rd; req_ready = 0; out_ready = 0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clock);
    lat = 1;
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom;
    chk("req_valid", 32'(req_valid), 32'(v.exp_req));
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    if (v.exp_req) begin
      chk("req_addr", req_addr, v.exp_raddr);
      chk("req_wen", 32'(req_wen), 32'(v.exp_wen));
      chk("req_wdata", req_wdata, v.exp_wdata);
      chk("req_wmask", 32'(req_wmask), 32'(v.exp_wmask));
      for (int i = 0; i < v.req_stall; i++) begin
        @(negedge clock);
        lat++;
        chk("req_hold", {req_valid, req_wen, req_wmask, in_ready},
            {1'b1, v.exp_wen, v.exp_wmask, 1'b0});
        chk("req_hold_addr", req_addr, v.exp_raddr);
        chk("req_hold_wdata", req_wdata, v.exp_wdata);
      end
      req_ready = 1;
      if (dirty) begin
        resp_valid = 1; resp_rdata = ~v.rdata; resp_err = ~v.err;
      end
      @(negedge clock);
      lat++;
      req_ready = 0;
      chk("req_drop", 32'(req_valid), 32'd0);
      chk("early_resp_ignored", 32'(out_valid), 32'd0);
      resp_valid = 1; resp_rdata = v.rdata; resp_err = v.err;
      @(negedge clock);
      lat++;
      resp_valid = 0; resp_rdata = $urandom; resp_err = 0;
    end
    k = 0;
    while (!out_valid && k < 8) begin
      @(negedge clock);
      lat++; k++;
    end
    exp_lat = v.exp_req ? 3 + v.req_stall : 1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("out_data", out_data, v.exp_data);
    chk("out_rd", 32'(out_rd), 32'(v.exp_rd));
    chk("out_err", 32'(out_err), 32'(v.exp_err));
    for (int i = 0; i < v.out_stall; i++) begin
      @(negedge clock);
      chk("out_hold", {out_valid, out_err, out_rd, in_ready}, {1'b1, v.exp_err, v.exp_rd, 1'b0});
      chk("out_hold_data", out_data, v.exp_data);
    end
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
    chk("out_release", {out_valid, in_ready}, 32'b01);
  endtask

  vec_t dir[12];
  vec_t rv;
  logic [31:0] mem[16];
  logic [2:0]  f3s[5];

  initial begin
    reset = 1; in_valid = 0; in_addr = 0; in_wdata = 0; in_mem_rd = 0; in_mem_wr = 0;
    in_funct3 = 0; in_rd = 0; req_ready = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0;
    out_ready = 0;
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;

    //          addr          wdata        rd wr f3    rd     rdata        err rs os req raddr         wen wdata        wmask    data          rd    err
    dir[0]  = mk(32'h1234_5678, 32'h0,       0, 0, 3'd2, 5'd5,  32'h0,       0, 0, 0, 0, 32'h0,        0, 32'h0,       4'b0000, 32'h1234_5678, 5'd5, 0);
    dir[1]  = mk(32'h8000_0003, 32'h0,       1, 0, 3'd0, 5'd7,  32'h80AA_BBCC, 0, 0, 0, 1, 32'h8000_0000, 0, 32'h0,     4'b0000, 32'hFFFF_FF80, 5'd7, 0);
    dir[2]  = mk(32'h8000_0003, 32'h0,       1, 0, 3'd4, 5'd7,  32'h80AA_BBCC, 0, 0, 0, 1, 32'h8000_0000, 0, 32'h0,     4'b0000, 32'h0000_0080, 5'd7, 0);
    dir[3]  = mk(32'h8000_0002, 32'h0000_BEEF, 0, 1, 3'd1, 5'd9, 32'h0,       0, 0, 0, 1, 32'h8000_0000, 1, 32'hBEEF_0000, 4'b1100, 32'h0,   5'd0, 0);
    dir[4]  = mk(32'h8000_0001, 32'h0,       1, 0, 3'd2, 5'd3,  32'h0,       0, 0, 0, 0, 32'h0,        0, 32'h0,       4'b0000, 32'h8000_0001, 5'd3, 1);
    dir[5]  = mk(32'h8000_0002, 32'h0000_BEEF, 0, 1, 3'd1, 5'd9, 32'h0,       0, 3, 2, 1, 32'h8000_0000, 1, 32'hBEEF_0000, 4'b1100, 32'h0,   5'd0, 0);
    dir[6]  = mk(32'h8000_0002, 32'h0,       1, 0, 3'd1, 5'd2,  32'h8001_1234, 0, 0, 1, 1, 32'h8000_0000, 0, 32'h0,     4'b0000, 32'hFFFF_8001, 5'd2, 0);
    dir[7]  = mk(32'h8000_0004, 32'h0,       1, 0, 3'd2, 5'd4,  32'hDEAD_BEEF, 1, 1, 0, 1, 32'h8000_0004, 0, 32'h0,     4'b0000, 32'h0,         5'd4, 1);
    dir[8]  = mk(32'h8000_0001, 32'h1234_56AB, 0, 1, 3'd0, 5'd6, 32'h0,       0, 0, 0, 1, 32'h8000_0000, 1, 32'h3456_AB00, 4'b0010, 32'h0,   5'd0, 0);
    dir[9]  = mk(32'hCAFE_F00D, 32'h5555_5555, 1, 1, 3'd2, 5'd1, 32'h0,      0, 0, 0, 0, 32'h0,        0, 32'h0,       4'b0000, 32'hCAFE_F00D, 5'd1, 0);
    dir[10] = mk(32'h8000_0003, 32'h0,       1, 0, 3'd5, 5'd8,  32'h0,       0, 0, 0, 0, 32'h0,        0, 32'h0,       4'b0000, 32'h8000_0003, 5'd8, 1);
    dir[11] = mk(32'h8000_0006, 32'hFFFF_FFFF, 0, 1, 3'd2, 5'd8, 32'h0,      0, 0, 0, 0, 32'h0,        0, 32'h0,       4'b0000, 32'h8000_0006, 5'd0, 1);

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valids", {req_valid, out_valid, out_err, req_wen}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_req_fields", req_addr | req_wdata | 32'(req_wmask), 32'd0);
    reset = 0;

    for (int i = 0; i < 12; i++) do_txn(dir[i], i == 6);

    // Reset while waiting for the response; the late response must be dropped
    @(negedge clock);
    in_valid = 1; in_addr = 32'h8000_0008; in_mem_rd = 1; in_mem_wr = 0; in_funct3 = 3'd2; in_rd = 5'd11;
    @(negedge clock);
    in_valid = 0; req_ready = 1;
    @(negedge clock);
    req_ready = 0;
    chk("wait_reached", {req_valid, out_valid, in_ready}, 32'd0);
    #2 reset = 1;
    #1 chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 0; resp_valid = 1; resp_rdata = 32'h1357_9BDF; resp_err = 0;
    @(negedge clock);
    resp_valid = 0;
    chk("late_resp_out_valid", 32'(out_valid), 32'd0);
    chk("late_resp_in_ready", 32'(in_ready), 32'd1);
    chk("late_resp_out_data", out_data, 32'd0);
    @(negedge clock);
    chk("late_resp_still_idle", {out_valid, req_valid, in_ready}, 32'b001);

    // Random transactions against a small word memory
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      int sel;
      int idx;
      sel = $urandom_range(0, 3);
      rv.addr = (sel == 0) ? 32'($urandom) : 32'h8000_0000 + 32'($urandom_range(0, 63));
      rv.wdata = $urandom;
      rv.rd_en = (sel == 1) || (sel == 3);
      rv.wr_en = (sel == 2) || (sel == 3);
      rv.f3 = f3s[$urandom_range(0, 4)];
      rv.rd = 5'($urandom);
      idx = int'((rv.addr >> 2) % 16);
      rv.rdata = mem[idx];
      rv.err = ($urandom_range(0, 7) == 0);
      rv.req_stall = $urandom_range(0, 2);
      rv.out_stall = $urandom_range(0, 2);
      rv = ref_model(rv);
      do_txn(rv, $urandom_range(0, 1) == 1);
      if (rv.exp_wen && !rv.err)
        for (int b = 0; b < 4; b++)
          if (rv.exp_wmask[b]) mem[idx][8*b +: 8] = rv.exp_wdata[8*b +: 8];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24070003_lsu.md
YSYX_24070003_LSU -- requirements
Module: ysyx_24070003_lsu

Interface
REQ-001 SHALL have no parameters; data and address width fixed at 32.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  execute stage presents an instruction.
REQ-005 in_ready  out  1  LSU accepts; transfer when in_valid & in_ready.
REQ-006 in_addr  in  32  ALU result (effective address or writeback value).
REQ-007 in_wdata  in  32  store source (rs2).
REQ-008 in_mem_rd / in_mem_wr  in  1 each  load / store; both 0 = pass-through; both 1 illegal, treated as pass-through.
REQ-009 in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 in_rd  in  5  destination register index.
REQ-011 req_valid  out  1  memory request; req_ready in 1 memory accepts.
REQ-012 req_addr out 32 word-aligned ({addr[31:2],2'b00}); req_wen out 1; req_wdata out 32; req_wmask out 4.
REQ-013 resp_valid in 1; resp_rdata in 32; resp_err in 1 memory response.
REQ-014 out_valid out 1; out_ready in 1 handshake to writeback.
REQ-015 out_data out 32; out_rd out 5; out_err out 1 (misaligned or bus error).

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE: on accept, latch all inputs; mem op and aligned -> REQ; pass-through or misaligned -> DONE.
REQ-018 Misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0; no memory request issued, out_err=1, out_data=in_addr.
REQ-019 REQ: req_valid=1 with stable req_* until req_ready; then -> WAIT.
REQ-020 WAIT: on resp_valid capture resp_rdata/resp_err -> DONE; resp_valid in any other state SHALL be ignored.
REQ-021 DONE: out_valid=1, outputs stable until out_ready; then -> IDLE (no same-cycle re-accept).
REQ-022 Store: req_wmask = B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; req_wdata = in_wdata shifted left by 8*addr[1:0]; out_data=0, out_rd=0 (no writeback).
REQ-023 Load: byte/half lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; req_wmask=0, req_wen=0.
REQ-024 Pass-through: out_data=in_addr, out_err=0, latency 1 cycle accept-to-out_valid.
REQ-025 Memory op latency SHALL be minimum 3 cycles accept-to-out_valid (REQ 1, WAIT 1, DONE) with zero-wait memory.
REQ-026 out_err=resp_err on loads and stores; load with error SHALL give out_data=0.
REQ-027 resp_valid in same cycle as req_ready SHALL NOT be captured (response only counted in WAIT).

Reset
REQ-028 reset SHALL force IDLE immediately; in_ready=1, req_valid=0, out_valid=0, out_data=0, out_rd=0, out_err=0, all latched fields 0.
REQ-029 Reset mid-transaction SHALL abandon the request; a late resp_valid after reset SHALL be ignored.

Verification
REQ-030 Pass-through: addr=0x1234_5678, rd=5, out_ready=1 -> out_valid 1 cycle later, out_data=0x1234_5678, out_rd=5, no req_valid.
REQ-031 LB: addr=0x8000_0003, resp_rdata=0x80AA_BBCC -> out_data=0xFFFF_FF80; LBU same -> 0x0000_0080; req_addr=0x8000_0000.
REQ-032 SH: addr=0x8000_0002, wdata=0x0000_BEEF -> req_wmask=1100, req_wdata=0xBEEF_0000, req_wen=1, out_rd=0.
REQ-033 Misaligned LW addr=0x8000_0001 -> no req_valid, out_err=1, out_data=0x8000_0001 after 1 cycle.
REQ-034 Backpressure: req_ready low 3 cycles, out_ready low 2 cycles -> req_*/out_* stable throughout, in_ready=0 until out handshake.
REQ-035 Reset asserted in WAIT, resp_valid arrives after release -> state IDLE, out_valid stays 0.
